// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and frame layout for dac_spi_serializer.
// Holds the FSM state enum, default command nibble and frame bit positions.
package dac_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD
    } state_t;

    localparam int CMD_BITS = 4;
    localparam logic [CMD_BITS-1:0] CMD_DEFAULT = 4'b0011;

    // Default 16-bit frame: {cmd[15:12], sample[11:4], pad[3:0]}
    localparam int CMD_MSB  = 15;
    localparam int CMD_LSB  = 12;
    localparam int DATA_MSB = 11;
    localparam int DATA_LSB = 4;
    localparam int PAD_MSB  = 3;
    localparam int PAD_LSB  = 0;

endpackage

// File: rtl/dac_spi_serializer_fifo.sv
// sample_fifo: synchronous FIFO with separate occupancy count.
// Ports: i_clk, i_rst_n, i_push, i_pop, i_data -> o_data, o_full, o_empty, o_count
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_rd) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: buffers samples, sends each as an SPI mode-0 frame.
// Ports: clk, reset(n), clk_en, valid_in, sample_in, clear_overflow ->
//   sclk, mosi, cs_n, busy, fifo_full, overflow
module dac_spi_serializer
    import dac_spi_pkg::*;
#(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  FRAME_BITS = 16,
    parameter logic [CMD_BITS-1:0] CMD        = CMD_DEFAULT,
    parameter int                  CLK_DIV    = 4,
    parameter int                  CS_HIGH    = 2,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  clear_overflow,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  overflow
);

    localparam int PAD_BITS = FRAME_BITS - CMD_BITS - DATA_WIDTH;
    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int HOLD_W   = $clog2(CS_HIGH + 1);
    localparam int BIT_W    = $clog2(FRAME_BITS) + 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    state_t                w_state_nx;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [HOLD_W-1:0]     r_hold;
    logic [FRAME_BITS-1:0] r_shreg;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;
    logic                  r_overflow;

    logic                  w_tick;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_done;
    logic                  w_hold_end;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [CNT_W-1:0]      w_count;
    logic [FRAME_BITS-1:0] w_frame;

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (sample_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_frame = {CMD, w_head, {PAD_BITS{1'b0}}};

    assign w_push = clk_en & valid_in & (~w_full | w_pop);
    assign w_drop = clk_en & valid_in & w_full & ~w_pop;

    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_rise     = (r_state == SHIFT) & w_tick & ~r_sclk;
    assign w_fall     = (r_state == SHIFT) & w_tick & r_sclk;
    assign w_done     = (r_bitcnt == BIT_W'(FRAME_BITS));
    assign w_hold_end = (r_hold == HOLD_W'(CS_HIGH - 1));

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                w_pop      = clk_en;
                w_state_nx = SHIFT;
            end
            SHIFT: begin
                // Leave only after the low half following the last rise.
                if (w_fall && w_done) begin
                    w_state_nx = HOLD;
                end
            end
            HOLD: begin
                if (w_hold_end) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= '0;
            r_bitcnt <= '0;
            r_hold   <= '0;
            r_shreg  <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs_n   <= 1'b1;
        end else if (clk_en) begin
            unique case (r_state)
                LOAD: begin
                    r_shreg  <= w_frame;
                    r_mosi   <= w_frame[FRAME_BITS-1];
                    r_cs_n   <= 1'b0;
                    r_sclk   <= 1'b0;
                    r_div    <= '0;
                    r_bitcnt <= '0;
                end
                SHIFT: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_rise) begin
                        r_sclk   <= 1'b1;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    if (w_fall) begin
                        r_sclk <= 1'b0;
                        if (w_done) begin
                            r_cs_n <= 1'b1;
                            r_mosi <= 1'b0;
                            r_hold <= '0;
                        end else begin
                            // mosi changes on the falling edge, a full
                            // half-period ahead of the DAC's rising sample.
                            r_shreg <= r_shreg << 1;
                            r_mosi  <= r_shreg[FRAME_BITS-2];
                        end
                    end
                end
                HOLD: begin
                    r_hold <= r_hold + 1'b1;
                end
                default: begin
                    r_div <= r_div;
                end
            endcase
        end
    end

    // A drop wins over a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clk_en && clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign cs_n      = r_cs_n;
    assign busy      = (r_state != IDLE);
    assign fifo_full = (w_count == CNT_W'(FIFO_DEPTH));
    assign overflow  = r_overflow;

endmodule

// File: doc/dac_spi_serializer.md
# dac_spi_serializer

Downstream output stage of the reconstruction path. Accepts each 8-bit sample the reconstruction pipeline emits on its `valid_out`/`dac_out` pair and buffers it in a small FIFO. Each sample is then serialized as one 16-bit write frame to an external SPI DAC (mode 0). This block isolates the per-sample reconstruction rate from the slower SPI transfer and flags any samples lost to backpressure.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width from the reconstruction stage
- FRAME_BITS, 16, SPI frame length; frame = {CMD, sample, zero pad}
- CMD, 4'b0011, command nibble in frame bits [15:12] ("write and update")
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- CS_HIGH, 2, clk cycles cs_n held high between frames (≥1)
- FIFO_DEPTH, 4, sample buffer entries (power of two)

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; when low, no push, no FSM advance, no divider count, outputs hold
- valid_in  in  1  sample strobe (upstream valid_out)
- sample_in  in  DATA_WIDTH  unsigned DAC code (upstream dac_out)
- clear_overflow  in  1  synchronous clear of the overflow flag
- sclk  out  1  SPI clock, idles low
- mosi  out  1  SPI data, MSB first
- cs_n  out  1  SPI chip select, active low
- busy  out  1  high whenever the FSM is not in IDLE
- fifo_full  out  1  FIFO count == FIFO_DEPTH
- overflow  out  1  sticky: a sample was dropped

## Operation
- Reset (reset=0, asynchronous):
  - sclk=0, mosi=0, cs_n=1, busy=0, overflow=0.
  - FIFO emptied, FSM→IDLE, divider and bit counter cleared.
  - Applies immediately, including mid-frame. The partial frame is abandoned.
- Push: when clk_en & valid_in, the sample is written if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - overflow set has priority over a same-cycle clear_overflow.
- Frame word: {CMD, sample, 4'b0000}. Sample is in bits [11:4].
- FSM (states in package enum):
  - IDLE: cs_n=1, sclk=0. If FIFO is non-empty → LOAD.
  - LOAD (1 cycle): pop the FIFO head into the shift register, drive cs_n=0 and mosi=frame[15], clear the divider and bit counter → SHIFT.
  - SHIFT:
    - Divider counts CLK_DIV cycles per half-period, then toggles sclk.
    - On each falling toggle, the shift register shifts left and mosi takes the next bit.
    - After the FRAME_BITS-th rising edge and its following low half-period → HOLD.
  - HOLD: cs_n=1, sclk=0, mosi=0 for CS_HIGH cycles → IDLE.
- The FIFO may refill during any state. Back-to-back frames are separated only by HOLD and the IDLE/LOAD cycles.
- Bit counter width: clog2(FRAME_BITS)+1. FIFO pointers wrap modulo FIFO_DEPTH, with count kept separately.

## Timing
- Input sampled on posedge. Upstream drives on negedge, giving a half-cycle setup budget.
- Latency: valid_in at cycle 0 with empty FIFO and IDLE FSM:
  - FIFO write at edge 0.
  - LOAD at edge 1; cs_n falls after edge 2.
  - First sclk rise CLK_DIV cycles after LOAD exit.
- Frame period = 1 (IDLE) + 1 (LOAD) + 2·CLK_DIV·FRAME_BITS + CS_HIGH = 132 cycles at defaults.
  - Sustained input faster than 1 sample per 132 cycles eventually overflows.
- The DAC samples mosi on sclk rise. mosi is stable CLK_DIV cycles before each rise.
- clk_en low freezes all counters. sclk/cs_n hold their levels, so the SPI timing stretches without glitching.

## Structure
- Package dac_spi_pkg: state enum (IDLE, LOAD, SHIFT, HOLD), CMD default, frame-layout localparams (cmd/data/pad bit positions).
- Sub-module sample_fifo: synchronous FIFO, parameterized width/depth, with push/pop/full/empty/count.
- Top: FSM, divider, bit counter, shift register, overflow flag.

## Test plan
- Single sample 8'hA5 after reset:
  - 16 sclk rises capture 16'h3A50.
  - cs_n is low for exactly 128 cycles.
  - busy returns to 0 after 132 cycles.
- Burst of 6 samples on consecutive cycles, 8'h01..8'h06:
  - 8'h01..8'h05 are accepted (one pops during the burst, freeing a slot).
  - 8'h06 is dropped, overflow=1.
  - Frames 0x3010..0x3050 are sent in order.
- Push on the cycle where count=4 and LOAD pops: the sample is accepted, fifo_full stays 1, overflow stays 0.
- reset=0 mid-SHIFT (after 7 bits): cs_n=1, sclk=0 immediately. FIFO empty and no further frames after release.
- clk_en toggled 50% during a frame of 8'hFF: the frame content is still 16'h3FF0, and no sclk edge occurs while clk_en=0.
- overflow set, then clear_overflow pulse: overflow=0 the next cycle. Simultaneous drop and clear leaves overflow=1.
